// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared constants, entry type and helpers for the fetch stage.
//            PC_W   - PC / ROM address width
//            INST_W - instruction width
//            fetch_entry_t - one buffered {pc, instruction} pair
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

   localparam int PC_W   = 10;
   localparam int INST_W = 9;

   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [INST_W-1:0] inst;
   } fetch_entry_t;

   // Pointer width for a circular buffer of 'depth' entries (at least 1 bit).
   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Purpose  : DEPTH-entry circular buffer holding fetched {pc, inst} entries.
//            DEPTH need not be a power of two; pointers wrap explicitly.
// Ports    : Clk    - clock
//            ResetN - asynchronous active-low reset
//            push   - write din at the tail
//            pop    - advance the head
//            clear  - empty the buffer (overrides push/pop)
//            din    - entry to write
//            dout   - head entry (straight from storage, no bypass)
//            count  - number of valid entries, 0..DEPTH
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int  DEPTH   = 3,
   parameter type ENTRY_T = fetch_entry_t
)
(
   input  logic                       Clk,
   input  logic                       ResetN,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       clear,
   input  ENTRY_T                     din,
   output ENTRY_T                     dout,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int                PTR_W = ptr_width(DEPTH);
   localparam int                CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0]  LAST  = PTR_W'(DEPTH - 1);

   ENTRY_T           mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;

   function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
      return (p == LAST) ? '0 : p + PTR_W'(1);
   endfunction

   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         // Storage is cleared so the head reads as zero while in reset.
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= bump(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= bump(rd_ptr);
         end
         if (push && !pop) begin
            count <= count + CNT_W'(1);
         end else if (pop && !push) begin
            count <= count - CNT_W'(1);
         end
      end
   end

   assign dout = mem[rd_ptr];

   a_no_overflow : assert property (@(posedge Clk) disable iff (!ResetN)
      !(push && !clear && (count == CNT_W'(DEPTH))));

   a_no_underflow : assert property (@(posedge Clk) disable iff (!ResetN)
      !(pop && !clear && (count == '0)));

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Purpose  : Instruction-fetch stage. Issues the PC to a 1-cycle-latency ROM
//            under a credit rule, buffers returned {pc, inst} pairs and hands
//            them to the decoder with valid/ready. Flush discards wrong path.
// Ports    : Clk       - clock
//            ResetN    - asynchronous active-low reset
//            PcIn      - current PC
//            Flush     - branch taken this cycle
//            PcAdvance - PC enable (issue this cycle)
//            InstAddr  - ROM address (= PcIn)
//            InstRdEn  - ROM read strobe (= PcAdvance)
//            InstData  - ROM data, valid the cycle after InstRdEn
//            InstValid - head entry valid to decoder
//            DecReady  - decoder accepts head entry
//            InstOut   - head instruction
//            InstPc    - PC of head instruction
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int L     = PC_W,
   parameter int W     = INST_W,
   parameter int DEPTH = 3
)
(
   input  logic         Clk,
   input  logic         ResetN,
   input  logic [L-1:0] PcIn,
   input  logic         Flush,
   output logic         PcAdvance,
   output logic [L-1:0] InstAddr,
   output logic         InstRdEn,
   input  logic [W-1:0] InstData,
   output logic         InstValid,
   input  logic         DecReady,
   output logic [W-1:0] InstOut,
   output logic [L-1:0] InstPc
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [L-1:0] pc;
      logic [W-1:0] inst;
   } entry_t;

   logic             inflight;
   logic [L-1:0]     inflight_pc;
   logic [CNT_W-1:0] count;
   logic [CNT_W:0]   used;
   logic             push;
   logic             pop;
   entry_t           wr_entry;
   entry_t           head;

   // Credit counts stored entries plus the outstanding read. Same-cycle pops
   // are deliberately ignored so DecReady never reaches PcAdvance.
   assign used      = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
   assign PcAdvance = ResetN && !Flush && (used < (CNT_W + 1)'(DEPTH));
   assign InstRdEn  = PcAdvance;
   assign InstAddr  = PcIn;

   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         inflight    <= 1'b0;
         inflight_pc <= '0;
      end else begin
         // PcAdvance is already low on Flush, so an outstanding read dies here.
         inflight <= PcAdvance;
         if (PcAdvance) begin
            inflight_pc <= PcIn;
         end
      end
   end

   assign push          = inflight && !Flush;
   assign pop           = InstValid && DecReady && !Flush;
   assign wr_entry.pc   = inflight_pc;
   assign wr_entry.inst = InstData;

   fetch_fifo #(
      .DEPTH   (DEPTH),
      .ENTRY_T (entry_t)
   ) u_fifo (
      .Clk    (Clk),
      .ResetN (ResetN),
      .push   (push),
      .pop    (pop),
      .clear  (Flush),
      .din    (wr_entry),
      .dout   (head),
      .count  (count)
   );

   assign InstValid = (count != '0);
   assign InstOut   = head.inst;
   assign InstPc    = head.pc;

   a_credit : assert property (@(posedge Clk) disable iff (!ResetN)
      used <= (CNT_W + 1)'(DEPTH));

endmodule
`default_nettype wire

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Instruction-fetch stage sitting directly downstream of the program counter and upstream of the decoder. Each cycle it may issue the current PC to the synchronous instruction ROM, which returns data with 1-cycle latency. Returned {pc, instruction} pairs are buffered in a small FIFO and handed to the decoder with a valid/ready handshake. It throttles PC advance by credit and discards wrong-path instructions on a taken branch.

Parameters:
L, 10, PC / ROM address width
W, 9, instruction width
DEPTH, 3, FIFO entries; 3 gives full throughput under the credit rule

Ports:
Clk  input  1  clock, all state changes on posedge
ResetN  input  1  asynchronous, active-low reset
PcIn  input  L  current PC from the program counter
Flush  input  1  branch taken this cycle (BranchAbs or BranchRel asserted to the PC)
PcAdvance  output  1  PC may increment or branch this cycle (PC enable)
InstAddr  output  L  ROM address; equals PcIn
InstRdEn  output  1  ROM read strobe; equals PcAdvance
InstData  input  W  ROM data, valid the cycle after InstRdEn
InstValid  output  1  head FIFO entry valid to the decoder
DecReady  input  1  decoder accepts the head entry
InstOut  output  W  head instruction
InstPc  output  L  PC of the head instruction

Behaviour:
- Reset (ResetN=0, asynchronous, any time including mid-operation):
  - count=0, inflight=0, FIFO pointers=0.
  - InstValid=0, InstOut=0, InstPc=0, PcAdvance=0.
  - Reset takes effect immediately, without waiting for a clock edge. Operation resumes on the first posedge after ResetN=1.
- State:
  - count: 0..DEPTH, width $clog2(DEPTH+1).
  - inflight: 1 bit, set when a ROM read is outstanding.
  - inflight_pc: L bits, PC of the outstanding read.
- Issue rule, combinational from registers plus Flush:
  - PcAdvance = !Flush && (count + inflight < DEPTH).
  - Pop credit from the same cycle is not used, so there is no DecReady-to-PcAdvance path.
- On the issue edge: inflight <= 1 and inflight_pc <= PcIn. Otherwise inflight <= 0.
- Push: when inflight && !Flush, write {inflight_pc, InstData} at the tail and increment count.
- Pop: when InstValid && DecReady && !Flush, advance the head and decrement count.
- Simultaneous push and pop: count is unchanged and both pointers advance. With count=0 the pushed entry is visible next cycle; there is no bypass.
- Latency: PC issued at cycle t → ROM data at t+1 → InstValid at t+2.
- InstValid = (count != 0). InstOut and InstPc are driven from the head entry, registered storage only.
- Flush takes priority over everything. On that edge:
  - count <= 0, pointers reset, inflight <= 0.
  - Any returning ROM data is dropped, and any pop in the same cycle is void.
  - PcAdvance=0 that cycle, so the PC loads the branch target through its own branch path.
  - The target is issued the following cycle.
- Invariants:
  - Push never occurs with count==DEPTH.
  - Pop never occurs with count==0.
  - count + inflight ≤ DEPTH at all times.
  - Implementations carry assertions for these invariants.
- Ordering: entries leave in issue order, with no loss or duplication except the intended Flush discard.
- Wrap-around: FIFO pointers wrap modulo DEPTH, and DEPTH need not be a power of 2.
- PC arithmetic is not performed here. PcIn wrap at 2^L is the program counter's concern.

Decomposition:
- Package fetch_pkg:
  - PC_W (=10) and INST_W (=9) constants.
  - typedef struct packed {logic [PC_W-1:0] pc; logic [INST_W-1:0] inst;} fetch_entry_t.
- One sub-module, fetch_fifo: a parameterised DEPTH-entry circular buffer.
  - Ports: push, pop, clear, din, dout, count.
  - Same async active-low reset.
- Issue/credit logic and the inflight register live in fetch_queue.

Test Plan:
1. Reset mid-stream: drive ResetN=0 between clock edges while count=2 → InstValid, InstOut, InstPc and PcAdvance go to 0 before the next edge. After release, the first InstValid appears 2 cycles after the first PcAdvance.
2. Streaming: ROM[a]=a+9'h100, DecReady=1, PC from 0 → PcAdvance stays 1 every cycle. The decoder receives InstPc 0,1,2,3… with InstOut 0x100,0x101… one per cycle, with no gaps.
3. Backpressure: DecReady=0 from reset → exactly 3 issues (PC 0,1,2), then PcAdvance=0 with count=3. Raise DecReady → PC 0,1,2 are delivered in order, and PcAdvance re-asserts the cycle after the first pop.
4. Flush with a full queue and a read inflight: Flush=1 for 1 cycle, PC target 0x040 → next cycle InstValid=0 and count=0. InstPc=0x040 appears 2 cycles after its issue, and no stale entry is ever seen.
5. Flush coincident with DecReady=1 and InstValid=1 → the pop is void, nothing is counted as consumed, and the FIFO is empty next cycle.
6. Random DecReady (50%) over 1000 instructions with sporadic Flush → the scoreboard shows in-order, no loss, no duplication, and the count/inflight invariants are never violated.
